// File: rtl/pio_in_edge_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pio_in_edge_capture_if                                                     |
// | Avalon-MM slave bus bundle for the input PIO (address/select/write/read).  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface pio_in_edge_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/pio_in_edge_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pio_in_edge_capture                                                        |
// | Avalon-MM input PIO: synchronise, debounce, latch edges, maskable irq.     |
// | Optional feature macro: PIO_IN_DEBOUNCE_EN (debounce counters enabled).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pio_in_edge_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_in_edge_capture_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_debounced;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_debounced_next;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clear;
  logic             w_write;
  logic [31:0]      w_readdata;
  logic             w_unused_writedata;

  assign w_write            = bus.chipselect & ~bus.write_n;
  assign w_clear            = (w_write && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused_writedata = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int                   C_COUNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [C_COUNT_W-1:0] C_COUNT_MAX = C_COUNT_W'(DEBOUNCE_CYCLES - 1);

  // Each bit accepts a new level only after it has disagreed for DEBOUNCE_CYCLES clocks in a row.
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    logic [C_COUNT_W-1:0] r_count;
    logic                 w_differs;
    logic                 w_expired;

    assign w_differs = r_sync2[i] ^ r_debounced[i];
    assign w_expired = (r_count == C_COUNT_MAX);

    always_ff @(posedge clk) begin
      if (!reset_n || !w_differs || w_expired) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + C_COUNT_W'(1);
      end
    end

    assign w_debounced_next[i] = (w_differs && w_expired) ? r_sync2[i] : r_debounced[i];
  end
`else
  assign w_debounced_next = r_sync2;
`endif

  if (EDGE_MODE == 0) begin : g_edge_rise
    assign w_event = w_debounced_next & ~r_debounced;
  end else if (EDGE_MODE == 1) begin : g_edge_fall
    assign w_event = ~w_debounced_next & r_debounced;
  end else begin : g_edge_any
    assign w_event = w_debounced_next ^ r_debounced;
  end

  // A new event is OR-ed in after the clear so set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_debounced <= '0;
      r_edgecap   <= '0;
      r_irqmask   <= '0;
      irq         <= 1'b0;
    end else begin
      r_debounced <= w_debounced_next;
      r_edgecap   <= (r_edgecap & ~w_clear) | w_event;
      if (w_write && bus.address == 2'd2) begin
        r_irqmask <= bus.writedata[WIDTH-1:0];
      end
      irq <= |(r_edgecap & r_irqmask);
    end
  end

  always_comb begin
    w_readdata = '0;
    case (bus.address)
      2'd0:    w_readdata[WIDTH-1:0] = r_debounced;
      2'd2:    w_readdata[WIDTH-1:0] = r_irqmask;
      2'd3:    w_readdata[WIDTH-1:0] = r_edgecap;
      default: w_readdata = '0;
    endcase
  end

  assign bus.readdata = w_readdata;

endmodule
`default_nettype wire
